// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan receiver: segment patterns
// (active-low, bit order a..g from MSB to LSB) and the default digit count.
package seg_pkg;

  localparam int unsigned SEG_NDIG_DEFAULT = 8;

  // Active-low a..g patterns for hex digits 0..F.
  localparam logic [6:0] SEG_PAT_0 = 7'b0000001;
  localparam logic [6:0] SEG_PAT_1 = 7'b1001111;
  localparam logic [6:0] SEG_PAT_2 = 7'b0010010;
  localparam logic [6:0] SEG_PAT_3 = 7'b0000110;
  localparam logic [6:0] SEG_PAT_4 = 7'b1001100;
  localparam logic [6:0] SEG_PAT_5 = 7'b0100100;
  localparam logic [6:0] SEG_PAT_6 = 7'b0100000;
  localparam logic [6:0] SEG_PAT_7 = 7'b0001111;
  localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [6:0] SEG_PAT_9 = 7'b0000100;
  localparam logic [6:0] SEG_PAT_A = 7'b0001000;
  localparam logic [6:0] SEG_PAT_B = 7'b1100000;
  localparam logic [6:0] SEG_PAT_C = 7'b0110001;
  localparam logic [6:0] SEG_PAT_D = 7'b1000010;
  localparam logic [6:0] SEG_PAT_E = 7'b0110000;
  localparam logic [6:0] SEG_PAT_F = 7'b0111000;

  // All segments off.
  localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;

  // Entry i holds the pattern for hex value i.
  localparam logic [15:0][6:0] SEG_PAT_TAB = {
    SEG_PAT_F, SEG_PAT_E, SEG_PAT_D, SEG_PAT_C,
    SEG_PAT_B, SEG_PAT_A, SEG_PAT_9, SEG_PAT_8,
    SEG_PAT_7, SEG_PAT_6, SEG_PAT_5, SEG_PAT_4,
    SEG_PAT_3, SEG_PAT_2, SEG_PAT_1, SEG_PAT_0
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern decoder: 7-bit active-low a..g pattern
// to hex nibble, with flags for the blank pattern and unrecognised patterns.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       is_blank,
  output logic       is_err
);

  logic hit;

  // Table lookup; patterns are unique so at most one entry matches.
  always_comb begin
    nib      = 4'h0;
    hit      = 1'b0;
    is_blank = (pat == SEG_PAT_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_PAT_TAB[i]) begin
        nib = 4'(i);
        hit = 1'b1;
      end
    end
    is_err = !hit && !is_blank;
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Seven-segment scan receiver: samples a multiplexed display bus, waits for a
// digit select / segment pair to be stable, then decodes it into a per-digit
// image and tracks when every digit has been refreshed (a frame).
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int unsigned NDIG       = SEG_NDIG_DEFAULT,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an_n,
  input  logic [7:0]        seg_n,
  input  logic              clr,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   err,
  output logic [NDIG-1:0]   dp,
  output logic              cap_valid,
  output logic [2:0]        cap_idx,
  output logic              frame_done
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYC);

  logic [NDIG-1:0]   samp_an_q;
  logic [7:0]        samp_seg_q;
  logic [7:0]        stab_q, stab_d;
  logic              same, legal, fire;

  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   blank_q, blank_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   seen_q, seen_d, seen_or, sel;
  logic              cap_valid_q, cap_valid_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic              frame_done_q, frame_done_d;

  logic [3:0]        dec_nib;
  logic              dec_blank, dec_err;

  // The captured pair always equals the sampled pair, so decode the register.
  seg_decode u_dec (
    .pat      (samp_seg_q[7:1]),
    .nib      (dec_nib),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  assign same  = (an_n == samp_an_q) && (seg_n == samp_seg_q);
  assign legal = ($countones(~an_n) == 1);
  assign sel   = ~samp_an_q;

  // Stability counter: restarts on a new legal pair, drops to 0 when illegal.
  always_comb begin
    stab_d = stab_q;
    if (clr || !legal) begin
      stab_d = 8'd0;
    end else if (!same) begin
      stab_d = 8'd1;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end
  end

  // Capture only on the edge the counter first reaches the threshold.
  assign fire = !clr && (stab_d == STAB_MAX) && (stab_q != STAB_MAX);

  // Capture, image update and frame tracking next-state.
  always_comb begin
    digits_d     = digits_q;
    blank_d      = blank_q;
    err_d        = err_q;
    dp_d         = dp_q;
    seen_d       = seen_q;
    cap_valid_d  = 1'b0;
    cap_idx_d    = cap_idx_q;
    frame_done_d = 1'b0;
    seen_or      = seen_q | sel;
    if (clr) begin
      digits_d = '0;
      blank_d  = '0;
      err_d    = '0;
      dp_d     = '0;
      seen_d   = '0;
    end else if (fire) begin
      cap_valid_d = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
        if (sel[i]) begin
          cap_idx_d = 3'(i);
          if (dec_blank) begin
            blank_d[i] = 1'b1;
            err_d[i]   = 1'b0;
          end else if (dec_err) begin
            blank_d[i] = 1'b0;
            err_d[i]   = 1'b1;
          end else begin
            digits_d[4*i +: 4] = dec_nib;
            blank_d[i]         = 1'b0;
            err_d[i]           = 1'b0;
            dp_d[i]            = ~samp_seg_q[0];
          end
        end
      end
      // The digit completing a frame also opens the next one.
      if (&seen_or) begin
        frame_done_d = 1'b1;
        seen_d       = sel;
      end else begin
        seen_d = seen_or;
      end
    end
  end

  // Input sample register and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_an_q  <= '1;
      samp_seg_q <= '1;
      stab_q     <= 8'd0;
    end else begin
      samp_an_q  <= an_n;
      samp_seg_q <= seg_n;
      stab_q     <= stab_d;
    end
  end

  // Captured image, pulses and frame mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q     <= '0;
      blank_q      <= '1;
      err_q        <= '0;
      dp_q         <= '0;
      seen_q       <= '0;
      cap_valid_q  <= 1'b0;
      cap_idx_q    <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      dp_q         <= dp_d;
      seen_q       <= seen_d;
      cap_valid_q  <= cap_valid_d;
      cap_idx_q    <= cap_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digits     = digits_q;
  assign blank      = blank_q;
  assign err        = err_q;
  assign dp         = dp_q;
  assign cap_valid  = cap_valid_q;
  assign cap_idx    = cap_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: directed scenarios followed by random dwell traffic,
// all checked every cycle against a behavioural display model.
module tb_seg_scan_rx;

  localparam int NDIG = 8;
  localparam int STAB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an_n = 8'hff;
  logic [7:0]  seg_n = 8'hff;
  logic        clr = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank, err, dp;
  logic        cap_valid, frame_done;
  logic [2:0]  cap_idx;

  seg_scan_rx #(.NDIG(NDIG), .STABLE_CYC(STAB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .clr        (clr),
    .digits     (digits),
    .blank      (blank),
    .err        (err),
    .dp         (dp),
    .cap_valid  (cap_valid),
    .cap_idx    (cap_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cap = 0;
  int n_fd = 0;

  logic [6:0]  pat_tab [16];

  // Model state: length of the current dwell and the display image.
  int          run;
  logic [15:0] prev;
  logic [31:0] m_digits;
  logic [7:0]  m_blank, m_err, m_dp, m_seen;
  logic        m_cv, m_fd;
  logic [2:0]  m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; prev = 16'hffff;
    m_digits = '0; m_blank = 8'hff; m_err = '0; m_dp = '0; m_seen = '0;
    m_cv = 1'b0; m_fd = 1'b0; m_idx = 3'd0;
  endtask

  task automatic model_edge(input logic [7:0] an, input logic [7:0] seg, input logic c);
    int pos, val;
    m_cv = 1'b0; m_fd = 1'b0;
    if (c || $countones(~an) != 1) run = 0;
    else if ({an, seg} != prev) run = 1;
    else run++;
    prev = {an, seg};
    if (c) begin
      m_digits = '0; m_blank = '0; m_err = '0; m_dp = '0; m_seen = '0;
    end else if (run == STAB) begin
      pos = 0;
      for (int i = 0; i < NDIG; i++) if (!an[i]) pos = i;
      val = -1;
      for (int v = 0; v < 16; v++) if (seg[7:1] == pat_tab[v]) val = v;
      m_cv = 1'b1; m_idx = 3'(pos);
      if (seg[7:1] == 7'h7f) begin
        m_blank[pos] = 1'b1; m_err[pos] = 1'b0;
      end else if (val < 0) begin
        m_blank[pos] = 1'b0; m_err[pos] = 1'b1;
      end else begin
        m_digits[4*pos +: 4] = 4'(val);
        m_blank[pos] = 1'b0; m_err[pos] = 1'b0; m_dp[pos] = ~seg[0];
      end
      m_seen[pos] = 1'b1;
      if (m_seen == 8'hff) begin
        m_fd = 1'b1;
        m_seen = 8'h00;
        m_seen[pos] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("digits", digits, m_digits);
    chk("blank", 32'(blank), 32'(m_blank));
    chk("err", 32'(err), 32'(m_err));
    chk("dp", 32'(dp), 32'(m_dp));
    chk("cap_valid", 32'(cap_valid), 32'(m_cv));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (m_cv) chk("cap_idx", 32'(cap_idx), 32'(m_idx));
  endtask

  // Drive one cycle of input, let the model see the same edge, then compare.
  task automatic step(input logic [7:0] an, input logic [7:0] seg, input logic c);
    an_n = an; seg_n = seg; clr = c;
    @(posedge clk);
    model_edge(an, seg, c);
    #1;
    check_all();
    if (cap_valid) n_cap++;
    if (frame_done) n_fd++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("rst_cap_idx", 32'(cap_idx), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] segv(input int v, input logic dp_on);
    return {pat_tab[v], ~dp_on};
  endfunction

  initial begin
    logic [7:0] an, seg;
    int hold, r;
    pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_blank", 32'(blank), 32'h000000ff);

    // Digit 0 showing "1." : capture on the 4th edge.
    n_cap = 0;
    for (int k = 0; k < 4; k++) step(8'b11111110, 8'b10011110, 1'b0);
    chk("d0_digit", 32'(digits[3:0]), 32'd1);
    chk("d0_dp", 32'(dp[0]), 32'd1);
    chk("d0_cap_valid", 32'(cap_valid), 32'd1);
    chk("d0_cap_idx", 32'(cap_idx), 32'd0);
    // Keep holding to 20 cycles: still only one capture.
    for (int k = 0; k < 16; k++) step(8'b11111110, 8'b10011110, 1'b0);
    chk("hold20_caps", 32'(n_cap), 32'd1);

    // Full scan 0..7, frame completes on digit 7.
    n_fd = 0;
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 5; k++) begin
        step(~(8'h01 << d), segv(d, 1'b0), 1'b0);
        if (d == 7 && k == 3) chk("scan_fd_edge", 32'(frame_done), 32'd1);
      end
    end
    chk("scan_digits", digits, 32'h76543210);
    chk("scan_fd_count", 32'(n_fd), 32'd1);

    // Two digits selected: never captured.
    n_cap = 0;
    for (int k = 0; k < 10; k++) step(8'b11111100, segv(8, 1'b0), 1'b0);
    chk("illegal_caps", 32'(n_cap), 32'd0);
    for (int k = 0; k < 4; k++) step(8'b11110111, 8'b11111110, 1'b0);
    chk("blank3", 32'(blank[3]), 32'd1);
    chk("blank3_digit", 32'(digits[15:12]), 32'd3);
    for (int k = 0; k < 4; k++) step(8'b11110111, 8'b01010100, 1'b0);
    chk("err3", 32'(err[3]), 32'd1);
    chk("err3_blank", 32'(blank[3]), 32'd0);

    // Segment glitch on the 3rd cycle of a dwell delays the capture.
    n_cap = 0;
    step(8'b11111011, segv(9, 1'b0), 1'b0);
    step(8'b11111011, segv(9, 1'b0), 1'b0);
    step(8'b11111011, segv(9, 1'b1), 1'b0);
    for (int k = 0; k < 3; k++) step(8'b11111011, segv(9, 1'b0), 1'b0);
    chk("glitch_early", 32'(n_cap), 32'd0);
    step(8'b11111011, segv(9, 1'b0), 1'b0);
    chk("glitch_cap", 32'(cap_valid), 32'd1);
    chk("glitch_digit", 32'(digits[11:8]), 32'd9);

    // Clear lands on the capture edge.
    for (int k = 0; k < 3; k++) step(8'b11011111, segv(10, 1'b1), 1'b0);
    step(8'b11011111, segv(10, 1'b1), 1'b1);
    chk("clr_cv", 32'(cap_valid), 32'd0);
    chk("clr_digits", digits, 32'd0);
    chk("clr_flags", {8'd0, blank, err, dp}, 32'd0);

    // Reset in the middle of a dwell, then a fresh full dwell.
    step(8'b11101111, segv(4, 1'b0), 1'b0);
    step(8'b11101111, segv(4, 1'b0), 1'b0);
    do_reset();
    n_cap = 0;
    for (int k = 0; k < 3; k++) step(8'b11101111, segv(4, 1'b0), 1'b0);
    chk("rst_dwell_early", 32'(n_cap), 32'd0);
    step(8'b11101111, segv(4, 1'b0), 1'b0);
    chk("rst_dwell_cap", 32'(cap_valid), 32'd1);

    // Random dwells with occasional illegal selects, junk patterns and clears.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) an = ~(8'h01 << $urandom_range(0, 7));
      else an = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) seg = {pat_tab[$urandom_range(0, 15)], 1'($urandom)};
      else if (r < 8) seg = {7'h7f, 1'($urandom)};
      else seg = 8'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) step(an, seg, ($urandom_range(0, 29) == 0));
      if (t == 40) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_rx.md
SEG_SCAN_RX -- requirements
Module: seg_scan_rx

Interface
REQ-001 Parameter NDIG, default 8: number of multiplexed digits, also the width of an_n.
REQ-002 Parameter STABLE_CYC, default 4: number of consecutive identical samples required before a capture (legal range 2..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 an_n  input  NDIG  digit select, active-low, one-hot-low when legal.
REQ-006 seg_n  input  8  segment bus, active-low; [7:1] = a..g, [0] = dp.
REQ-007 clr  input  1  synchronous clear of the captured image and the frame tracking.
REQ-008 digits  output  4*NDIG  decoded hex value per digit; digit i occupies [4i+3:4i].
REQ-009 blank  output  NDIG  per-digit flag: last capture was all segments off.
REQ-010 err  output  NDIG  per-digit flag: last capture was an undecodable pattern.
REQ-011 dp  output  NDIG  per-digit decimal-point state (1 = lit).
REQ-012 cap_valid  output  1  one-cycle pulse: a capture was written this cycle.
REQ-013 cap_idx  output  3  index of the digit captured; meaningful only while cap_valid is high.
REQ-014 frame_done  output  1  one-cycle pulse: every digit has been captured since the last frame_done or clr.

Function
REQ-015 seg_scan_rx SHALL register an_n and seg_n into a one-stage sample register on every clock edge.
REQ-016 A sample SHALL be legal only when exactly one bit of an_n is 0.
REQ-017 stab_cnt SHALL increment, saturating at STABLE_CYC, while the incoming pair equals the sampled pair and that pair is legal.
REQ-018 stab_cnt SHALL reset to 1 on any change of the pair, and to 0 on an illegal pair.
REQ-019 A capture SHALL occur on the edge where stab_cnt reaches STABLE_CYC, exactly once per dwell; no re-capture until the pair changes.
REQ-020 Capture latency: on input held constant from edge k, the outputs update and cap_valid asserts at edge k+STABLE_CYC.
REQ-021 Decoding SHALL use seg_n[7:1] only: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 A blank pattern (1111111) SHALL set blank[i]=1 and err[i]=0 and leave digits[i] unchanged.
REQ-023 Any other pattern SHALL set err[i]=1 and blank[i]=0 and leave digits[i] unchanged.
REQ-024 A legal pattern SHALL write digits[i], clear blank[i] and err[i], and set dp[i] = ~seg_n[0].
REQ-025 A seen[NDIG] mask SHALL set bit i on each capture.
REQ-026 frame_done SHALL pulse on the edge where seen becomes all-ones; seen SHALL clear on that same edge, except for the bit captured on that edge, which starts the new frame.
REQ-027 clr SHALL zero digits, blank, err, dp, seen and stab_cnt, and SHALL suppress any capture on the same edge (clr wins).
REQ-028 Re-capturing a digit already in seen SHALL update its outputs without affecting frame progress.

Reset
REQ-029 While rst_n=0: digits=0, blank=all-ones, err=0, dp=0, cap_valid=0, cap_idx=0, frame_done=0, seen=0, stab_cnt=0, sample register = all-ones.
REQ-030 Reset asserted mid-dwell SHALL abandon the dwell; after release, a full STABLE_CYC of stable samples is required before the next capture.

Structure
REQ-031 Package seg_pkg SHALL hold the 16 pattern constants, the blank pattern, and the NDIG default.
REQ-032 The combinational pattern decoder SHALL be one sub-module, seg_decode (7-bit pattern -> nibble, is_blank, is_err).
REQ-033 Sampling, stability counting, capture and frame tracking SHALL live in seg_scan_rx.

Verification
REQ-034 an_n=8'b11111110, seg_n=8'b10011110 held 4 cycles -> digits[3:0]=1, dp[0]=1, cap_valid pulses once, cap_idx=0.
REQ-035 Same pair held 20 cycles -> exactly one cap_valid pulse.
REQ-036 Scan digits 0..7 with patterns for 0..7, 5 cycles each -> digits=32'h76543210, frame_done pulses once, on the digit-7 capture edge.
REQ-037 an_n=8'b11111100 held 10 cycles -> no capture; seg_n=8'b11111110 on digit 3 -> blank[3]=1; seg_n=8'b01010100 on digit 3 -> err[3]=1.
REQ-038 Glitch of seg_n on the 3rd cycle of a dwell -> capture delayed to 4 cycles after the glitch clears.
REQ-039 clr on the capture edge -> no cap_valid and all outputs zero; rst_n low mid-dwell -> reset values, then a fresh 4-cycle dwell is required.
